// File: rtl/prescaled_counter_pkg.sv
// Shared definitions for the prescaled up/down counter.
package prescaled_counter_pkg;

    // Direction and limit-mode encodings seen on up_dn / sat_mode
    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // What the count register does on a given edge (reset handled separately)
    typedef enum logic [1:0] {
        ACT_IDLE = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_STEP = 2'd2
    } cnt_action_e;

endpackage

// File: rtl/prescaled_counter_if.sv
// Control/status bundle of the prescaled counter.
// master = whoever drives the controls, slave = the counter itself.
interface prescaled_counter_if #(
    parameter int SIZE  = 4,
    parameter int PRE_W = 4
);
    logic             enable;
    logic [PRE_W-1:0] div_ratio;
    logic             up_dn;
    logic             sat_mode;
    logic             load;
    logic [SIZE-1:0]  load_val;
    logic [SIZE-1:0]  count;
    logic             tick;
    logic             tc;

    modport master (
        output enable, div_ratio, up_dn, sat_mode, load, load_val,
        input  count, tick, tc
    );

    modport slave (
        input  enable, div_ratio, up_dn, sat_mode, load, load_val,
        output count, tick, tc
    );
endinterface

// File: rtl/prescaled_counter_prescale_ctrl.sv
// Run-length prescaler: raises tick for one cycle once enable has been
// high for eff_div consecutive edges. Any enable drop or load restarts it.
module prescale_ctrl #(
    parameter int PRE_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [PRE_W-1:0] div_ratio_i,
    output logic             tick_o
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick_q, tick_d;
    logic [PRE_W-1:0] last_cnt;

    // div_ratio of 0 and 1 both mean "every clock", so the terminal value is 0.
    // Compare with >= so that lowering div_ratio mid-run fires immediately.
    always_comb begin
        last_cnt  = (div_ratio_i <= PRE_W'(1)) ? '0 : div_ratio_i - PRE_W'(1);
        pre_cnt_d = '0;
        tick_d    = 1'b0;
        if (enable_i && !load_i) begin
            if (pre_cnt_q >= last_cnt) begin
                tick_d = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
        end
    end

    // Prescaler state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/prescaled_counter.sv
// Up/down counter stepped by the prescaler tick, with parallel load,
// wrap/saturate limits and a one-cycle terminal-count pulse.
module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int PRE_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    prescaled_counter_if.slave bus
);

    localparam logic [SIZE-1:0] CNT_MAX = '1;

    logic            tick;
    logic [SIZE-1:0] count_q, count_d;
    logic            tc_q, tc_d;
    cnt_action_e     act;

    prescale_ctrl #(.PRE_W(PRE_W)) u_prescale (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (bus.enable),
        .load_i      (bus.load),
        .div_ratio_i (bus.div_ratio),
        .tick_o      (tick)
    );

    // Load beats a pending tick; a step does not look at enable, so a tick
    // already earned is still taken if enable drops on the same cycle.
    always_comb begin
        if (bus.load) begin
            act = ACT_LOAD;
        end else if (tick) begin
            act = ACT_STEP;
        end else begin
            act = ACT_IDLE;
        end
    end

    // Next count and terminal-count flag; tc marks any step taken at a limit
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        case (act)
            ACT_LOAD: count_d = bus.load_val;
            ACT_STEP: begin
                if (bus.up_dn == CNT_UP) begin
                    if (count_q == CNT_MAX) begin
                        tc_d    = 1'b1;
                        count_d = (bus.sat_mode == MODE_SAT) ? CNT_MAX : '0;
                    end else begin
                        count_d = count_q + SIZE'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        tc_d    = 1'b1;
                        count_d = (bus.sat_mode == MODE_SAT) ? '0 : CNT_MAX;
                    end else begin
                        count_d = count_q - SIZE'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Count and tc registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick;
    assign bus.tc    = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter (SIZE=4, PRE_W=4).
module tb_prescaled_counter;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_cnt[5];
    int   exp_tc[5];

    prescaled_counter_if #(.SIZE(4), .PRE_W(4)) ifc ();

    prescaled_counter #(.SIZE(4), .PRE_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        ifc.enable   = 1'b0;
        ifc.load     = 1'b0;
        edge1();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        ifc.enable    = 1'b0;
        ifc.div_ratio = 4'd3;
        ifc.up_dn     = 1'b1;
        ifc.sat_mode  = 1'b0;
        ifc.load      = 1'b0;
        ifc.load_val  = 4'd0;

        // Reset state
        do_reset();
        chk("rst_count", 32'(ifc.count), 0);
        chk("rst_tick",  32'(ifc.tick),  0);
        chk("rst_tc",    32'(ifc.tc),    0);

        // 1: div 3, up; ticks at 3,6,9; steps at 4,7,10 (edge 10 with enable low)
        ifc.enable = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            if (e == 10) ifc.enable = 1'b0;
            edge1();
            chk($sformatf("t1_tick_e%0d", e),  32'(ifc.tick),  (e % 3 == 0) ? 1 : 0);
            chk($sformatf("t1_count_e%0d", e), 32'(ifc.count), (e - 1) / 3);
            chk($sformatf("t1_tc_e%0d", e),    32'(ifc.tc),    0);
        end

        // 2: enable broken after 2 edges restarts qualification
        do_reset();
        ifc.div_ratio = 4'd3;
        ifc.enable    = 1'b1;
        edge1(); edge1();
        chk("t2_tick_e2", 32'(ifc.tick), 0);
        ifc.enable = 1'b0;
        edge1();
        chk("t2_tick_e3", 32'(ifc.tick), 0);
        ifc.enable = 1'b1;
        edge1();
        chk("t2_tick_e4", 32'(ifc.tick), 0);
        edge1();
        chk("t2_tick_e5", 32'(ifc.tick), 0);
        edge1();
        chk("t2_tick_e6",  32'(ifc.tick),  1);
        chk("t2_count_e6", 32'(ifc.count), 0);
        edge1();
        chk("t2_count_e7", 32'(ifc.count), 1);

        // 3a: div 1, up, wrap from 13 -> 15 -> 0 with tc
        do_reset();
        ifc.div_ratio = 4'd1;
        ifc.up_dn     = 1'b1;
        ifc.sat_mode  = 1'b0;
        ifc.enable    = 1'b1;
        ifc.load      = 1'b1;
        ifc.load_val  = 4'd13;
        edge1();
        chk("t3_load_count", 32'(ifc.count), 13);
        chk("t3_load_tick",  32'(ifc.tick),  0);
        ifc.load = 1'b0;
        exp_cnt = '{13, 14, 15, 0, 1};
        exp_tc  = '{0, 0, 0, 1, 0};
        for (int e = 0; e < 5; e++) begin
            edge1();
            chk($sformatf("t3u_count_%0d", e), 32'(ifc.count), exp_cnt[e]);
            chk($sformatf("t3u_tc_%0d", e),    32'(ifc.tc),    exp_tc[e]);
            chk($sformatf("t3u_tick_%0d", e),  32'(ifc.tick),  1);
        end

        // 3b: div 0, down, wrap from 2 -> 0 -> 15 with tc
        ifc.div_ratio = 4'd0;
        ifc.up_dn     = 1'b0;
        ifc.load      = 1'b1;
        ifc.load_val  = 4'd2;
        edge1();
        chk("t3d_load_count", 32'(ifc.count), 2);
        ifc.load = 1'b0;
        exp_cnt = '{2, 1, 0, 15, 14};
        exp_tc  = '{0, 0, 0, 1, 0};
        for (int e = 0; e < 5; e++) begin
            edge1();
            chk($sformatf("t3d_count_%0d", e), 32'(ifc.count), exp_cnt[e]);
            chk($sformatf("t3d_tc_%0d", e),    32'(ifc.tc),    exp_tc[e]);
        end

        // 4a: saturate up from 14
        ifc.div_ratio = 4'd1;
        ifc.sat_mode  = 1'b1;
        ifc.up_dn     = 1'b1;
        ifc.load      = 1'b1;
        ifc.load_val  = 4'd14;
        edge1();
        ifc.load = 1'b0;
        exp_cnt = '{14, 15, 15, 15, 15};
        exp_tc  = '{0, 0, 1, 1, 1};
        for (int e = 0; e < 4; e++) begin
            edge1();
            chk($sformatf("t4u_count_%0d", e), 32'(ifc.count), exp_cnt[e]);
            chk($sformatf("t4u_tc_%0d", e),    32'(ifc.tc),    exp_tc[e]);
        end

        // 4b: saturate down from 1; load clears a live tc
        ifc.up_dn    = 1'b0;
        ifc.load     = 1'b1;
        ifc.load_val = 4'd1;
        edge1();
        chk("t4d_load_tc",    32'(ifc.tc),    0);
        chk("t4d_load_count", 32'(ifc.count), 1);
        ifc.load = 1'b0;
        exp_cnt = '{1, 0, 0, 0, 0};
        exp_tc  = '{0, 0, 1, 1, 1};
        for (int e = 0; e < 4; e++) begin
            edge1();
            chk($sformatf("t4d_count_%0d", e), 32'(ifc.count), exp_cnt[e]);
            chk($sformatf("t4d_tc_%0d", e),    32'(ifc.tc),    exp_tc[e]);
        end

        // 6a: rst together with load while tick and tc are high
        chk("t6_pre_tick", 32'(ifc.tick), 1);
        chk("t6_pre_tc",   32'(ifc.tc),   1);
        rst          = 1'b1;
        ifc.load     = 1'b1;
        ifc.load_val = 4'd9;
        edge1();
        chk("t6_rst_count", 32'(ifc.count), 0);
        chk("t6_rst_tick",  32'(ifc.tick),  0);
        chk("t6_rst_tc",    32'(ifc.tc),    0);
        rst      = 1'b0;
        ifc.load = 1'b0;

        // 6b: div 7 -> 2 while pre_cnt = 5 fires on the next edge
        ifc.sat_mode  = 1'b0;
        ifc.up_dn     = 1'b1;
        ifc.div_ratio = 4'd7;
        ifc.enable    = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            edge1();
            chk($sformatf("t6_tick_e%0d", e), 32'(ifc.tick), 0);
        end
        ifc.div_ratio = 4'd2;
        edge1();
        chk("t6_tick_e6",  32'(ifc.tick),  1);
        chk("t6_count_e6", 32'(ifc.count), 0);
        edge1();
        chk("t6_count_e7", 32'(ifc.count), 1);

        // 5: load on the tick edge discards the step and restarts prescaler
        do_reset();
        ifc.div_ratio = 4'd3;
        ifc.up_dn     = 1'b1;
        ifc.enable    = 1'b1;
        edge1(); edge1(); edge1();
        chk("t5_tick_e3", 32'(ifc.tick), 1);
        ifc.load     = 1'b1;
        ifc.load_val = 4'd9;
        edge1();
        chk("t5_load_count", 32'(ifc.count), 9);
        chk("t5_load_tc",    32'(ifc.tc),    0);
        chk("t5_load_tick",  32'(ifc.tick),  0);
        ifc.load = 1'b0;
        edge1();
        chk("t5_tick_e5", 32'(ifc.tick), 0);
        edge1();
        chk("t5_tick_e6", 32'(ifc.tick), 0);
        edge1();
        chk("t5_tick_e7",  32'(ifc.tick),  1);
        chk("t5_count_e7", 32'(ifc.count), 9);
        edge1();
        chk("t5_count_e8", 32'(ifc.count), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
